// File: rtl/hazard_ctrl_pkg.sv
// Shared types and constants for the pipeline hazard controller.
// Covers the controller state, the forwarding operand select and the PC register index.
package hazard_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        MEMWAIT = 2'd1,
        ERROR   = 2'd2
    } state_t;

    typedef enum logic [1:0] {
        FWD_RF  = 2'b00,
        FWD_WB  = 2'b01,
        FWD_MEM = 2'b10
    } fwd_sel_t;

    // Writes to r15 go through the PC path, so they are never forwarded or treated as load-use.
    localparam logic [3:0] PC_REG = 4'd15;

endpackage

// File: rtl/hazard_ctrl_if.sv
// Pipeline-side signal bundle for hazard_ctrl.
// The core drives it through the master modport; the controller uses the slave modport.
interface hazard_ctrl_if #(
    parameter int CNT_W = 16
);
    logic [3:0]       RA1D, RA2D, RA1E, RA2E;
    logic [3:0]       WA3E, WA3M, WA3W;
    logic             RegWriteM, RegWriteW;
    logic             MemtoRegE, BranchTakenE;
    logic             MemReqM, MemReadyM;
    logic             StallF, StallD, StallE, StallM;
    logic             FlushD, FlushE, FlushW;
    logic [1:0]       ForwardAE, ForwardBE;
    logic             MemErr;
    logic [CNT_W-1:0] StallCount;

    modport master (
        output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
               RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, MemReqM, MemReadyM,
        input  StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               ForwardAE, ForwardBE, MemErr, StallCount
    );

    modport slave (
        input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
               RegWriteM, RegWriteW, MemtoRegE, BranchTakenE, MemReqM, MemReadyM,
        output StallF, StallD, StallE, StallM, FlushD, FlushE, FlushW,
               ForwardAE, ForwardBE, MemErr, StallCount
    );
endinterface

// File: rtl/hazard_ctrl_fwd_unit.sv
// Operand forwarding select for one Execute-stage source register.
// The Memory-stage result is newer than the Writeback result, so it wins.
module fwd_unit
    import hazard_ctrl_pkg::*;
(
    input  logic [3:0] ra_e,
    input  logic [3:0] wa3_m,
    input  logic [3:0] wa3_w,
    input  logic       reg_write_m,
    input  logic       reg_write_w,
    output fwd_sel_t   fwd
);

    // NOTE: every always_comb output gets a value on every path, here via a full if/else chain, so no latch is inferred.
    always_comb begin
        if (reg_write_m && (wa3_m == ra_e) && (wa3_m != PC_REG)) begin
            fwd = FWD_MEM;
        end else if (reg_write_w && (wa3_w == ra_e) && (wa3_w != PC_REG)) begin
            fwd = FWD_WB;
        end else begin
            fwd = FWD_RF;
        end
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Stall/flush/forward controller for the 5-stage ARM pipeline, with data-memory
// wait sequencing, a sticky timeout error and a saturating stall-cycle counter.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16,
    parameter int CNT_W          = 16
) (
    input  logic         clk,
    input  logic         reset,
    hazard_ctrl_if.slave hz
);

    localparam int               WAIT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(TIMEOUT_CYCLES - 1);

    state_t             state, state_n;
    logic [WAIT_W-1:0]  wait_cnt, wait_cnt_n;
    logic [CNT_W-1:0]   stall_count;
    fwd_sel_t           fwd_a, fwd_b;
    logic               mem_stall, branch_flush, load_use;

    fwd_unit u_fwd_a (
        .ra_e        (hz.RA1E),
        .wa3_m       (hz.WA3M),
        .wa3_w       (hz.WA3W),
        .reg_write_m (hz.RegWriteM),
        .reg_write_w (hz.RegWriteW),
        .fwd         (fwd_a)
    );

    fwd_unit u_fwd_b (
        .ra_e        (hz.RA2E),
        .wa3_m       (hz.WA3M),
        .wa3_w       (hz.WA3W),
        .reg_write_m (hz.RegWriteM),
        .reg_write_w (hz.RegWriteW),
        .fwd         (fwd_b)
    );

    // A frozen memory access outranks everything; the E-stage branch or load re-resolves afterwards.
    assign mem_stall    = (hz.MemReqM && !hz.MemReadyM) || (state == ERROR);
    assign branch_flush = !mem_stall && hz.BranchTakenE;
    assign load_use     = !mem_stall && !hz.BranchTakenE && hz.MemtoRegE &&
                          (hz.WA3E != PC_REG) &&
                          ((hz.WA3E == hz.RA1D) || (hz.WA3E == hz.RA2D));

    always_comb begin
        state_n    = state;
        wait_cnt_n = wait_cnt;
        case (state)
            RUN: begin
                if (hz.MemReqM && !hz.MemReadyM) begin
                    state_n    = MEMWAIT;
                    wait_cnt_n = WAIT_W'(1);
                end
            end
            MEMWAIT: begin
                if (hz.MemReadyM) begin
                    state_n    = RUN;
                    wait_cnt_n = '0;
                end else if (wait_cnt == WAIT_LAST) begin
                    state_n = ERROR;
                end else begin
                    wait_cnt_n = wait_cnt + 1'b1;
                end
            end
            ERROR:   state_n = ERROR;
            default: state_n = RUN;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= RUN;
            wait_cnt    <= '0;
            stall_count <= '0;
        end else begin
            state    <= state_n;
            wait_cnt <= wait_cnt_n;
            if ((mem_stall || load_use) && (stall_count != '1)) begin
                stall_count <= stall_count + 1'b1;
            end
        end
    end

    assign hz.StallF     = mem_stall || load_use;
    assign hz.StallD     = mem_stall || load_use;
    assign hz.StallE     = mem_stall;
    assign hz.StallM     = mem_stall;
    assign hz.FlushD     = branch_flush;
    assign hz.FlushE     = branch_flush || load_use;
    assign hz.FlushW     = mem_stall;
    assign hz.ForwardAE  = fwd_a;
    assign hz.ForwardBE  = fwd_b;
    assign hz.MemErr     = (state == ERROR);
    assign hz.StallCount = stall_count;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a vector table for the single-cycle hazard rules,
// plus hand sequences for memory waits, timeout, counter saturation and reset recovery.
module tb_hazard_ctrl;
    import hazard_ctrl_pkg::*;

    localparam int         TIMEOUT = 8;
    localparam int         CNT_W   = 4;
    localparam int         CNT_MAX = (1 << CNT_W) - 1;
    localparam logic [6:0] C_NONE  = 7'b0000000;
    localparam logic [6:0] C_LU    = 7'b1100010;
    localparam logic [6:0] C_BR    = 7'b0000110;
    localparam logic [6:0] C_MEM   = 7'b1111001;

    typedef struct packed {
        logic [3:0] ra1d, ra2d, ra1e, ra2e, wa3e, wa3m, wa3w;
        logic       rwm, rww, m2r, br;
        logic [6:0] ctl;
        logic [1:0] fa, fb;
    } vec_t;

    logic clk = 1'b0;
    logic reset;
    int   n_tests = 0;
    int   n_fail  = 0;
    int   exp_cnt = 0;
    vec_t vecs [14];

    hazard_ctrl_if #(.CNT_W(CNT_W)) hz ();

    hazard_ctrl #(.TIMEOUT_CYCLES(TIMEOUT), .CNT_W(CNT_W)) dut (
        .clk   (clk),
        .reset (reset),
        .hz    (hz)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [6:0] ctl_now();
        return {hz.StallF, hz.StallD, hz.StallE, hz.StallM, hz.FlushD, hz.FlushE, hz.FlushW};
    endfunction

    task automatic apply(input vec_t v, input logic req, input logic rdy);
        hz.RA1D = v.ra1d; hz.RA2D = v.ra2d; hz.RA1E = v.ra1e; hz.RA2E = v.ra2e;
        hz.WA3E = v.wa3e; hz.WA3M = v.wa3m; hz.WA3W = v.wa3w;
        hz.RegWriteM = v.rwm; hz.RegWriteW = v.rww;
        hz.MemtoRegE = v.m2r; hz.BranchTakenE = v.br;
        hz.MemReqM = req; hz.MemReadyM = rdy;
    endtask

    // Advance one clock and update the expected saturating stall count.
    task automatic step(input logic exp_stall);
        @(posedge clk);
        if (reset) exp_cnt = 0;
        else if (exp_stall && exp_cnt != CNT_MAX) exp_cnt++;
        @(negedge clk);
    endtask

    initial begin
        //            ra1d  ra2d  ra1e  ra2e  wa3e  wa3m  wa3w rwm  rww  m2r  br   ctl     fa     fb
        vecs[0]  = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0,1'b0,1'b0,1'b0,C_NONE,2'b00,2'b00};
        vecs[1]  = '{4'd0, 4'd0, 4'd3, 4'd0, 4'd0, 4'd3, 4'd3, 1'b1,1'b1,1'b0,1'b0,C_NONE,2'b10,2'b00};
        vecs[2]  = '{4'd0, 4'd0, 4'd3, 4'd0, 4'd0, 4'd15,4'd3, 1'b1,1'b1,1'b0,1'b0,C_NONE,2'b01,2'b00};
        vecs[3]  = '{4'd0, 4'd0, 4'd3, 4'd0, 4'd0, 4'd15,4'd3, 1'b1,1'b0,1'b0,1'b0,C_NONE,2'b00,2'b00};
        vecs[4]  = '{4'd0, 4'd0, 4'd0, 4'd7, 4'd0, 4'd7, 4'd7, 1'b1,1'b1,1'b0,1'b0,C_NONE,2'b00,2'b10};
        vecs[5]  = '{4'd0, 4'd0, 4'd0, 4'd7, 4'd0, 4'd2, 4'd7, 1'b1,1'b1,1'b0,1'b0,C_NONE,2'b00,2'b01};
        vecs[6]  = '{4'd0, 4'd0, 4'd15,4'd15,4'd0, 4'd15,4'd15,1'b1,1'b1,1'b0,1'b0,C_NONE,2'b00,2'b00};
        vecs[7]  = '{4'd0, 4'd5, 4'd0, 4'd0, 4'd5, 4'd0, 4'd0, 1'b0,1'b0,1'b1,1'b0,C_LU,  2'b00,2'b00};
        vecs[8]  = '{4'd5, 4'd0, 4'd0, 4'd0, 4'd5, 4'd0, 4'd0, 1'b0,1'b0,1'b1,1'b0,C_LU,  2'b00,2'b00};
        vecs[9]  = '{4'd15,4'd15,4'd0, 4'd0, 4'd15,4'd0, 4'd0, 1'b0,1'b0,1'b1,1'b0,C_NONE,2'b00,2'b00};
        vecs[10] = '{4'd0, 4'd5, 4'd0, 4'd0, 4'd5, 4'd0, 4'd0, 1'b0,1'b0,1'b1,1'b1,C_BR,  2'b00,2'b00};
        vecs[11] = '{4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 4'd0, 1'b0,1'b0,1'b0,1'b1,C_BR,  2'b00,2'b00};
        vecs[12] = '{4'd0, 4'd5, 4'd0, 4'd0, 4'd5, 4'd0, 4'd0, 1'b0,1'b0,1'b0,1'b0,C_NONE,2'b00,2'b00};
        vecs[13] = '{4'd4, 4'd0, 4'd6, 4'd4, 4'd4, 4'd6, 4'd4, 1'b1,1'b1,1'b1,1'b0,C_LU,  2'b10,2'b01};

        // Reset held for two edges with idle inputs.
        reset = 1'b1;
        apply(vecs[0], 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        check("reset_ctl", ctl_now(), C_NONE);
        check("reset_fwd", {hz.ForwardAE, hz.ForwardBE}, 4'b0000);
        check("reset_memerr", hz.MemErr, 1'b0);
        check("reset_count", hz.StallCount, 0);
        reset   = 1'b0;
        exp_cnt = 0;

        // Single-cycle hazard rules from the table.
        for (int i = 0; i < 14; i++) begin
            apply(vecs[i], 1'b0, 1'b0);
            #1;
            check($sformatf("vec%0d_ctl", i), ctl_now(), vecs[i].ctl);
            check($sformatf("vec%0d_fwda", i), hz.ForwardAE, vecs[i].fa);
            check($sformatf("vec%0d_fwdb", i), hz.ForwardBE, vecs[i].fb);
            check($sformatf("vec%0d_count", i), hz.StallCount, exp_cnt);
            step(vecs[i].ctl[6]);
        end

        // Three not-ready memory cycles with a concurrent taken branch, then ready.
        apply(vecs[11], 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("memwait%0d_ctl", i), ctl_now(), C_MEM);
            step(1'b1);
        end
        apply(vecs[11], 1'b1, 1'b1);
        #1;
        check("memready_ctl", ctl_now(), C_BR);
        check("memready_count", hz.StallCount, exp_cnt);
        step(1'b0);
        apply(vecs[7], 1'b0, 1'b0);
        #1;
        check("after_wait_lu", ctl_now(), C_LU);
        check("after_wait_memerr", hz.MemErr, 1'b0);
        step(1'b1);

        // Timeout: ERROR after TIMEOUT edges of not-ready, stall count saturates.
        apply(vecs[0], 1'b1, 1'b0);
        for (int i = 0; i < 20; i++) begin
            #1;
            check($sformatf("timeout%0d_ctl", i), ctl_now(), C_MEM);
            check($sformatf("timeout%0d_memerr", i), hz.MemErr, (i >= TIMEOUT));
            check($sformatf("timeout%0d_count", i), hz.StallCount, exp_cnt);
            step(1'b1);
        end
        apply(vecs[11], 1'b0, 1'b0);
        #1;
        check("error_sticky_ctl", ctl_now(), C_MEM);
        check("error_sticky_memerr", hz.MemErr, 1'b1);
        check("error_count_sat", hz.StallCount, CNT_MAX);
        step(1'b1);

        // One-cycle reset out of ERROR.
        reset = 1'b1;
        apply(vecs[0], 1'b0, 1'b0);
        step(1'b0);
        reset = 1'b0;
        #1;
        check("rst_err_ctl", ctl_now(), C_NONE);
        check("rst_err_memerr", hz.MemErr, 1'b0);
        check("rst_err_count", hz.StallCount, 0);
        apply(vecs[0], 1'b1, 1'b0);
        step(1'b1);
        apply(vecs[0], 1'b1, 1'b1);
        #1;
        check("rst_then_ready_ctl", ctl_now(), C_NONE);
        check("rst_then_ready_memerr", hz.MemErr, 1'b0);
        check("rst_then_ready_count", hz.StallCount, exp_cnt);
        step(1'b0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
